// File: rtl/triangle_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : defines_package
//  Brief    : Shared geometry types (Point2D, Triangle2D) and the scheduler
//             state encoding (TriSchedState) so that monitors can decode it.
//  Revision : 1.0 - initial release
// ============================================================================
package defines_package;

    // Signed screen-space coordinate width
    localparam int c_COORD_W = 16;

    typedef struct packed {
        logic signed [c_COORD_W-1:0] x;
        logic signed [c_COORD_W-1:0] y;
    } Point2D;

    typedef struct packed {
        Point2D p;
        Point2D q;
        Point2D r;
    } Triangle2D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FDONE = 2'd3
    } TriSchedState;

endpackage
`default_nettype wire

// File: rtl/triangle_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_scheduler_if
//  Brief    : Triangle source handshake plus rasterizer start/done handshake.
//             master = environment side, slave = scheduler side.
//  Revision : 1.0 - initial release
// ============================================================================
interface triangle_scheduler_if;
    import defines_package::*;

    logic      tri_valid;
    Triangle2D tri_in;
    logic      tri_ready;
    logic      frame_end;
    logic      rast_start;
    Triangle2D rast_triangle;
    logic      rast_done;

    modport master (
        output tri_valid, tri_in, frame_end, rast_done,
        input  tri_ready, rast_start, rast_triangle
    );

    modport slave (
        input  tri_valid, tri_in, frame_end, rast_done,
        output tri_ready, rast_start, rast_triangle
    );

endinterface
`default_nettype wire

// File: rtl/triangle_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tri_fifo
//  Brief    : Synchronous FIFO of Triangle2D entries with show-ahead read
//             (dout always presents the head entry). DEPTH is a power of two
//             so the pointers wrap naturally.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_fifo
    import defines_package::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire Triangle2D              din,
    output Triangle2D                   dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW+1)'(DEPTH);

    Triangle2D        r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full   = (r_level == c_FULL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rd_ptr];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/triangle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_scheduler
//  Brief    : Queues incoming triangles and issues them one at a time to the
//             rasterizer controller; signals frame_done once every triangle
//             of a frame has been drawn.
//             Optional macro TRISCHED_STATS_EN adds tri_count / busy_cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module triangle_scheduler
    import defines_package::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    triangle_scheduler_if.slave         bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(DEPTH):0]      level
`ifdef TRISCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]            tri_count,
    output logic [CNT_W-1:0]            busy_cycles
`endif
);

    // Elaboration-time parameter sanity
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("triangle_scheduler: DEPTH must be a power of two >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("triangle_scheduler: CNT_W must be >= 1");
    end

    TriSchedState   r_state;
    TriSchedState   w_next;
    logic           r_frame_pending;
    logic           r_rast_start;
    logic           r_frame_done;
    Triangle2D      r_rast_triangle;

    logic           w_push;
    logic           w_pop;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    Triangle2D      w_fifo_dout;
    logic [$clog2(DEPTH):0] w_level;

    // Next frame's triangles are held off until the pending frame completes
    assign bus.tri_ready = !w_fifo_full && !r_frame_pending;
    assign w_push        = bus.tri_valid && bus.tri_ready;
    // The head is consumed on exactly the edge that enters ISSUE
    assign w_pop         = (w_next == ISSUE);

    tri_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.tri_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_level)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; queued work takes priority over frame completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_next = ISSUE;
                end else if (r_frame_pending) begin
                    w_next = FDONE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (bus.rast_done) begin
                    if (!w_fifo_empty) begin
                        w_next = ISSUE;
                    end else if (r_frame_pending) begin
                        w_next = FDONE;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            FDONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Registered outputs: start/done pulses follow the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rast_start    <= 1'b0;
            r_frame_done    <= 1'b0;
            r_rast_triangle <= '0;
        end else begin
            r_rast_start <= (w_next == ISSUE);
            r_frame_done <= (w_next == FDONE);
            if (w_pop) begin
                r_rast_triangle <= w_fifo_dout;
            end
        end
    end

    // Frame pending flag; a repeated frame_end while pending merges into it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_pending <= 1'b0;
        end else if (r_state == FDONE) begin
            r_frame_pending <= 1'b0;
        end else if (bus.frame_end) begin
            r_frame_pending <= 1'b1;
        end
    end

    assign bus.rast_start    = r_rast_start;
    assign bus.rast_triangle = r_rast_triangle;
    assign frame_done        = r_frame_done;
    assign level             = w_level;
    assign busy              = (w_level != '0) || (r_state == ISSUE) || (r_state == WAIT);

`ifdef TRISCHED_STATS_EN
    logic [CNT_W-1:0] r_tri_count;
    logic [CNT_W-1:0] r_busy_cycles;

    // Saturating per-frame counters; cleared on the edge ending frame_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tri_count   <= '0;
            r_busy_cycles <= '0;
        end else if (r_frame_done) begin
            r_tri_count   <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (r_rast_start && (r_tri_count != '1)) begin
                r_tri_count <= r_tri_count + 1'b1;
            end
            if (busy && (r_busy_cycles != '1)) begin
                r_busy_cycles <= r_busy_cycles + 1'b1;
            end
        end
    end

    assign tri_count   = r_tri_count;
    assign busy_cycles = r_busy_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_triangle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_triangle_scheduler
//  Brief    : Directed self-checking bench for triangle_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_scheduler;
    import defines_package::*;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       frame_done;
    logic [2:0] level;
`ifdef TRISCHED_STATS_EN
    logic [15:0] tri_count;
    logic [15:0] busy_cycles;
`endif

    int n_checks;
    int n_errors;

    triangle_scheduler_if bus_if ();

    triangle_scheduler #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done),
        .level      (level)
`ifdef TRISCHED_STATS_EN
        ,
        .tri_count  (tri_count),
        .busy_cycles(busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic Triangle2D mk(input int px, input int py, input int qx,
                                     input int qy, input int rx, input int ry);
        Triangle2D t;
        t.p.x = 16'(px); t.p.y = 16'(py);
        t.q.x = 16'(qx); t.q.y = 16'(qy);
        t.r.x = 16'(rx); t.r.y = 16'(ry);
        return t;
    endfunction

    // From WAIT: pulse rast_done, expect immediate reissue of exp, then WAIT
    task automatic issue_next(input Triangle2D exp);
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("b2b_start", bus_if.rast_start, 1'b1);
        check("issue_order", bus_if.rast_triangle, exp);
        step();
        check("start_one_cycle", bus_if.rast_start, 1'b0);
    endtask

    Triangle2D t1, b0, b1, c0, d0, d1, d2;
    Triangle2D a [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        t1 = mk(1, 2, 5, 2, 3, 7);
        for (int i = 0; i < 6; i++) a[i] = mk(10 + i, 20 + i, 30 + i, 40 + i, 50 + i, 60 + i);
        b0 = mk(-3, 4, 8, 4, 2, 9);
        b1 = mk(7, 7, 11, 1, 0, 5);
        c0 = mk(100, 200, 300, 200, 150, 400);
        d0 = mk(9, 9, 9, 19, 19, 9);
        d1 = mk(1, 1, 2, 2, 3, 1);
        d2 = mk(4, 4, 6, 4, 5, 8);

        rst = 1'b1;
        bus_if.tri_valid = 1'b0;
        bus_if.tri_in    = '0;
        bus_if.frame_end = 1'b0;
        bus_if.rast_done = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_tri_ready", bus_if.tri_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_rast_start", bus_if.rast_start, 1'b0);
        check("rst_rast_tri", bus_if.rast_triangle, 96'd0);
`ifdef TRISCHED_STATS_EN
        check("rst_tri_count", tri_count, 16'd0);
        check("rst_busy_cycles", busy_cycles, 16'd0);
`endif
        rst = 1'b0;
        step();

        // Single triangle: push, issue two edges later, done drops busy
        bus_if.tri_valid = 1'b1;
        bus_if.tri_in    = t1;
        step();
        bus_if.tri_valid = 1'b0;
        bus_if.tri_in    = '0;
        check("single_level", level, 3'd1);
        check("single_no_start_yet", bus_if.rast_start, 1'b0);
        check("single_busy", busy, 1'b1);
        step();
        check("single_start", bus_if.rast_start, 1'b1);
        check("single_tri", bus_if.rast_triangle, t1);
        step();
        check("single_start_pulse", bus_if.rast_start, 1'b0);
        check("single_busy_wait", busy, 1'b1);
        repeat (5) step();
        check("single_tri_stable", bus_if.rast_triangle, t1);
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("single_busy_low", busy, 1'b0);
        check("single_no_restart", bus_if.rast_start, 1'b0);
        step();

        // Fill: 5 pushes, first is issued, 4 remain and FIFO is full
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", bus_if.tri_ready, 1'b1);
            bus_if.tri_valid = 1'b1;
            bus_if.tri_in    = a[i];
            step();
        end
        bus_if.tri_in = a[5];
        check("fill_level", level, 3'd4);
        check("fill_not_ready", bus_if.tri_ready, 1'b0);
        check("fill_first_issued", bus_if.rast_triangle, a[0]);
        step();
        step();
        check("fill_held", level, 3'd4);
        bus_if.tri_valid = 1'b0;
        bus_if.tri_in    = '0;
        for (int i = 1; i < 5; i++) begin
            issue_next(a[i]);
            check("drain_level", level, 3'(4 - i));
            check("drain_ready", bus_if.tri_ready, 1'b1);
        end
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("fill_end_busy", busy, 1'b0);
        check("fill_end_level", level, 3'd0);
        step();

        // Empty frame: frame_done two cycles after frame_end, no start
        bus_if.frame_end = 1'b1;
        step();
        bus_if.frame_end = 1'b0;
        check("ef_no_done_yet", frame_done, 1'b0);
        check("ef_ready_low", bus_if.tri_ready, 1'b0);
        step();
        check("ef_done", frame_done, 1'b1);
        check("ef_no_start", bus_if.rast_start, 1'b0);
`ifdef TRISCHED_STATS_EN
        check("ef_tri_count", tri_count, 16'd6);
`endif
        step();
        check("ef_done_pulse", frame_done, 1'b0);
        check("ef_ready_back", bus_if.tri_ready, 1'b1);
`ifdef TRISCHED_STATS_EN
        check("ef_tri_count_clr", tri_count, 16'd0);
        check("ef_busy_cycles_clr", busy_cycles, 16'd0);
`endif

        // Frame boundary: 2 triangles, frame_end together with the 2nd push
        bus_if.tri_valid = 1'b1;
        bus_if.tri_in    = b0;
        step();
        bus_if.tri_in    = b1;
        bus_if.frame_end = 1'b1;
        step();
        bus_if.frame_end = 1'b0;
        bus_if.tri_in    = c0;
        check("fb_simul_push", level, 3'd1);
        check("fb_ready_low", bus_if.tri_ready, 1'b0);
        check("fb_start0", bus_if.rast_start, 1'b1);
        check("fb_tri0", bus_if.rast_triangle, b0);
        step();
        check("fb_pending_hold", level, 3'd1);
        bus_if.rast_done = 1'b1;
        bus_if.frame_end = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        bus_if.frame_end = 1'b0;
        check("fb_tri1", bus_if.rast_triangle, b1);
        check("fb_no_early_done", frame_done, 1'b0);
        step();
        check("fb_no_early_done2", frame_done, 1'b0);
        check("fb_ready_low2", bus_if.tri_ready, 1'b0);
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("fb_done", frame_done, 1'b1);
        check("fb_ready_low3", bus_if.tri_ready, 1'b0);
        check("fb_level0", level, 3'd0);
`ifdef TRISCHED_STATS_EN
        check("fb_tri_count", tri_count, 16'd2);
        check("fb_busy_cycles", busy_cycles, 16'd5);
`endif
        step();
        check("fb_done_once", frame_done, 1'b0);
        check("fb_ready_back", bus_if.tri_ready, 1'b1);
        check("fb_held_not_in", level, 3'd0);
        step();
        bus_if.tri_valid = 1'b0;
        bus_if.tri_in    = '0;
        check("fb_held_accepted", level, 3'd1);
        step();
        check("fb_next_start", bus_if.rast_start, 1'b1);
        check("fb_next_tri", bus_if.rast_triangle, c0);
        check("fb_no_second_done", frame_done, 1'b0);
        step();
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("fb_idle", busy, 1'b0);

        // Reset mid-draw: one in flight, two queued
        bus_if.tri_valid = 1'b1;
        bus_if.tri_in    = d0;
        step();
        bus_if.tri_in    = d1;
        step();
        bus_if.tri_in    = d2;
        step();
        bus_if.tri_valid = 1'b0;
        bus_if.tri_in    = '0;
        check("rm_level", level, 3'd2);
        check("rm_busy", busy, 1'b1);
        check("rm_tri_in_flight", bus_if.rast_triangle, d0);
        #3;
        rst = 1'b1;
        #1;
        check("rm_async_level", level, 3'd0);
        check("rm_async_busy", busy, 1'b0);
        check("rm_async_ready", bus_if.tri_ready, 1'b1);
        check("rm_async_tri", bus_if.rast_triangle, 96'd0);
        check("rm_async_start", bus_if.rast_start, 1'b0);
        step();
        rst = 1'b0;
        bus_if.rast_done = 1'b1;
        step();
        bus_if.rast_done = 1'b0;
        check("rm_no_start", bus_if.rast_start, 1'b0);
        step();
        check("rm_no_start2", bus_if.rast_start, 1'b0);
        check("rm_idle", busy, 1'b0);
        check("rm_no_frame_done", frame_done, 1'b0);
`ifdef TRISCHED_STATS_EN
        check("rm_tri_count", tri_count, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
